if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter NOP_INST, default 32'h0000_0013, giving the bubble instruction (addi x0,x0,0).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port PC_EN_IF, input, 1 bit: PC update enable from the hazard detection unit.
REQ-006 The block SHALL have port reg_FD_EN, input, 1 bit: IF/ID register global enable.
REQ-007 The block SHALL have port reg_FD_stall, input, 1 bit: hold the IF/ID contents.
REQ-008 The block SHALL have port reg_FD_flush, input, 1 bit: replace the IF/ID contents with a bubble.
REQ-009 The block SHALL have port Branch_ID, input, 1 bit: the taken branch/jump resolved in ID.
REQ-010 The block SHALL have port PC_branch_ID, input, 32 bits: the branch/jump target from ID.
REQ-011 The block SHALL have port inst_IF, input, 32 bits: the instruction memory read data, combinational from PC_IF.
REQ-012 The block SHALL have port PC_IF, output, 32 bits: the current fetch address driving instruction memory.
REQ-013 The block SHALL have port PC_ID, output, 32 bits: the PC of the instruction held in ID.
REQ-014 The block SHALL have port inst_ID, output, 32 bits: the instruction held in ID.
REQ-015 The block SHALL have port valid_ID, output, 1 bit: set when inst_ID is a real fetched instruction, clear when it is a bubble.
REQ-016 The block SHALL have port stall_cnt, output, 16 bits: a saturating count of IF/ID stall cycles.
REQ-017 The block SHALL have port flush_cnt, output, 16 bits: a saturating count of IF/ID flush cycles.

Function
REQ-018 The PC register SHALL update only when PC_EN_IF=1, and SHALL otherwise hold its value.
REQ-019 When PC_EN_IF=1 and Branch_ID=1, the PC SHALL load {PC_branch_ID[31:2],2'b00}, so the low 2 bits are always forced to zero.
REQ-020 When PC_EN_IF=1 and Branch_ID=0, the PC SHALL load PC_IF+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-021 The IF/ID register priority SHALL be: reg_FD_EN=0 holds everything; otherwise reg_FD_flush wins; otherwise reg_FD_stall holds; otherwise load.
REQ-022 A flush SHALL set inst_ID=NOP_INST, PC_ID=32'h0 and valid_ID=0 on the next edge.
REQ-023 A load SHALL set inst_ID=inst_IF, PC_ID=PC_IF and valid_ID=1 on the next edge, giving one-cycle IF-to-ID latency.
REQ-024 When flush and stall are asserted together, the flush SHALL win and be counted only in flush_cnt.
REQ-025 stall_cnt SHALL increment on each edge where reg_FD_EN=1, reg_FD_stall=1 and reg_FD_flush=0, saturating at 16'hFFFF.
REQ-026 flush_cnt SHALL increment on each edge where reg_FD_EN=1 and reg_FD_flush=1, saturating at 16'hFFFF.
REQ-027 Counters SHALL NOT change when reg_FD_EN=0.
REQ-028 PC_EN_IF and the IF/ID controls SHALL act independently: a load-use stall (PC_EN_IF=0, stall=1) holds both the PC and ID, and a branch flush (PC_EN_IF=1, flush=1, Branch_ID=1) redirects the PC and bubbles ID in the same edge.
REQ-029 All outputs SHALL be driven directly from registers, with no combinational input-to-output paths.

Reset
REQ-030 While rst_n=0, the block SHALL asynchronously set PC_IF=RESET_PC, PC_ID=32'h0, inst_ID=NOP_INST, valid_ID=0, stall_cnt=0 and flush_cnt=0.
REQ-031 Reset asserted mid-stall or mid-flush SHALL take effect immediately, with all in-flight state discarded.
REQ-032 The first rising edge after rst_n deasserts SHALL perform a normal update according to the current inputs.

Verification
REQ-033 Sequential fetch: reset, then 3 edges with all enables=1, stall=0 and flush=0 -> PC_IF=0xC, PC_ID=0x8, inst_ID=inst_IF sampled at PC 0x8, and valid_ID=1.
REQ-034 Load-use stall: at PC_IF=0x10, apply PC_EN_IF=0 and stall=1 for 1 cycle -> PC_IF stays 0x10, PC_ID and inst_ID are unchanged, and stall_cnt increments by 1.
REQ-035 Branch: Branch_ID=1, PC_branch_ID=0x0000_0103, flush=1 -> PC_IF=0x100 next cycle, inst_ID=0x0000_0013, valid_ID=0, and flush_cnt increments by 1.
REQ-036 Wrap and priority: with PC_IF=0xFFFF_FFFC, apply PC_EN_IF=1, Branch_ID=0, stall=1 and flush=1 -> PC_IF=0x0, ID is bubbled, flush_cnt increments by 1, and stall_cnt is unchanged.
REQ-037 Saturation and disable: hold stall=1 for 65,540 cycles -> stall_cnt=0xFFFF; then apply reg_FD_EN=0 with flush=1 -> ID contents and flush_cnt are unchanged.
REQ-038 Async reset: pulse rst_n low between clock edges during a stall -> all outputs return to their reset values before the next edge.

Source files
------------

// File: rtl/if_id_stage.sv
// Fetch PC register and IF/ID pipeline register with hold/bubble control
// and saturating stall/flush event counters. All outputs come straight from flops.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_EN_IF,
  input  logic        reg_FD_EN,
  input  logic        reg_FD_stall,
  input  logic        reg_FD_flush,
  input  logic        Branch_ID,
  input  logic [31:0] PC_branch_ID,
  input  logic [31:0] inst_IF,
  output logic [31:0] PC_IF,
  output logic [31:0] PC_ID,
  output logic [31:0] inst_ID,
  output logic        valid_ID,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic [31:0] pc_nxt;
  logic        fd_flush, fd_stall, fd_load;

  // Branch targets are word-aligned by dropping the low two bits.
  assign pc_nxt   = Branch_ID ? {PC_branch_ID[31:2], 2'b00} : PC_IF + 32'd4;
  assign fd_flush = reg_FD_EN & reg_FD_flush;
  assign fd_stall = reg_FD_EN & reg_FD_stall & ~reg_FD_flush;
  assign fd_load  = reg_FD_EN & ~reg_FD_stall & ~reg_FD_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        PC_IF <= RESET_PC;
    else if (PC_EN_IF) PC_IF <= pc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC_ID    <= 32'h0;
      inst_ID  <= NOP_INST;
      valid_ID <= 1'b0;
    end else if (fd_flush) begin
      PC_ID    <= 32'h0;
      inst_ID  <= NOP_INST;
      valid_ID <= 1'b0;
    end else if (fd_load) begin
      PC_ID    <= PC_IF;
      inst_ID  <= inst_IF;
      valid_ID <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0;
      flush_cnt <= 16'h0;
    end else begin
      if (fd_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (fd_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a reference model checked every cycle
// plus hand-computed literal expectations at each scenario boundary.
module tb_if_id_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PC_EN_IF = 1'b0, reg_FD_EN = 1'b0, reg_FD_stall = 1'b0, reg_FD_flush = 1'b0;
  logic        Branch_ID = 1'b0;
  logic [31:0] PC_branch_ID = 32'h0;
  logic [31:0] inst_IF;
  logic [31:0] PC_IF, PC_ID, inst_ID;
  logic        valid_ID;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
    .reg_FD_stall(reg_FD_stall), .reg_FD_flush(reg_FD_flush), .Branch_ID(Branch_ID),
    .PC_branch_ID(PC_branch_ID), .inst_IF(inst_IF), .PC_IF(PC_IF), .PC_ID(PC_ID),
    .inst_ID(inst_ID), .valid_ID(valid_ID), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction
  assign inst_IF = imem(PC_IF);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the stage must hold after each edge.
  logic [31:0] m_pc = 32'h0, m_pc_id = 32'h0, m_inst = 32'h13;
  logic        m_valid = 1'b0;
  int          m_stalls = 0, m_flushes = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_pc_id = 32'h0; m_inst = 32'h13; m_valid = 1'b0;
      m_stalls = 0; m_flushes = 0;
    end else begin
      logic [31:0] fetched_pc;
      fetched_pc = m_pc;
      if (PC_EN_IF) m_pc = Branch_ID ? (PC_branch_ID & ~32'h3) : m_pc + 32'd4;
      if (reg_FD_EN) begin
        if (reg_FD_flush) begin
          m_pc_id = 32'h0; m_inst = 32'h13; m_valid = 1'b0;
          if (m_flushes < 65535) m_flushes++;
        end else if (reg_FD_stall) begin
          if (m_stalls < 65535) m_stalls++;
        end else begin
          m_pc_id = fetched_pc; m_inst = imem(fetched_pc); m_valid = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_pc_if",   PC_IF,   m_pc);
    chk("cyc_pc_id",   PC_ID,   m_pc_id);
    chk("cyc_inst_id", inst_ID, m_inst);
    chk("cyc_valid",   {31'h0, valid_ID}, {31'h0, m_valid});
    chk("cyc_stall",   {16'h0, stall_cnt}, m_stalls);
    chk("cyc_flush",   {16'h0, flush_cnt}, m_flushes);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic pc_en, input logic en, input logic st,
                       input logic fl, input logic br, input logic [31:0] tgt);
    PC_EN_IF = pc_en; reg_FD_EN = en; reg_FD_stall = st; reg_FD_flush = fl;
    Branch_ID = br; PC_branch_ID = tgt;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_pc_if", PC_IF, 32'h0);
    chk("rst_inst",  inst_ID, 32'h13);
    chk("rst_valid", {31'h0, valid_ID}, 32'h0);
    chk("rst_cnts",  {stall_cnt, flush_cnt}, 32'h0);

    // Sequential fetch: three edges
    drive(1, 1, 0, 0, 0, 32'h0);
    rst_n = 1'b1;
    step(3);
    chk("seq_pc_if", PC_IF, 32'hC);
    chk("seq_pc_id", PC_ID, 32'h8);
    chk("seq_inst",  inst_ID, 32'h5A5A_000B);
    chk("seq_valid", {31'h0, valid_ID}, 32'h1);
    step(1);

    // Load-use stall at PC 0x10
    chk("pre_stall_pc", PC_IF, 32'h10);
    drive(0, 1, 1, 0, 0, 32'h0);
    step(1);
    chk("lu_pc_if", PC_IF, 32'h10);
    chk("lu_pc_id", PC_ID, 32'hC);
    chk("lu_inst",  inst_ID, 32'h5A5A_000F);
    chk("lu_stall", {16'h0, stall_cnt}, 32'h1);

    // Taken branch with flush; target low bits dropped
    drive(1, 1, 0, 1, 1, 32'h0000_0103);
    step(1);
    chk("br_pc_if", PC_IF, 32'h100);
    chk("br_inst",  inst_ID, 32'h13);
    chk("br_valid", {31'h0, valid_ID}, 32'h0);
    chk("br_flush", {16'h0, flush_cnt}, 32'h1);

    // Wrap and flush-over-stall priority
    drive(1, 1, 0, 0, 1, 32'hFFFF_FFFC);
    step(1);
    drive(1, 1, 1, 1, 0, 32'h0);
    step(1);
    chk("wr_pc_if",  PC_IF, 32'h0);
    chk("wr_pc_id",  PC_ID, 32'h0);
    chk("wr_valid",  {31'h0, valid_ID}, 32'h0);
    chk("wr_flush",  {16'h0, flush_cnt}, 32'h2);
    chk("wr_stall",  {16'h0, stall_cnt}, 32'h1);

    // Load PC 0, then long stall to saturation, then disabled flush
    drive(1, 1, 0, 0, 0, 32'h0);
    step(1);
    drive(0, 1, 1, 0, 0, 32'h0);
    step(65540);
    chk("sat_stall", {16'h0, stall_cnt}, 32'hFFFF);
    drive(0, 0, 0, 1, 0, 32'h0);
    step(1);
    chk("dis_inst",  inst_ID, 32'h5A5A_0003);
    chk("dis_valid", {31'h0, valid_ID}, 32'h1);
    chk("dis_flush", {16'h0, flush_cnt}, 32'h2);
    chk("dis_stall", {16'h0, stall_cnt}, 32'hFFFF);

    // Async reset pulse mid-stall, between edges
    drive(0, 1, 1, 0, 0, 32'h0);
    step(1);
    rst_n = 1'b0;
    #1;
    chk("ar_pc_if",  PC_IF, 32'h0);
    chk("ar_inst",   inst_ID, 32'h13);
    chk("ar_valid",  {31'h0, valid_ID}, 32'h0);
    chk("ar_cnts",   {stall_cnt, flush_cnt}, 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_stall", {16'h0, stall_cnt}, 32'h1);
    chk("post_rst_pc",    PC_IF, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
